p_mul_seq: RTL and testbench
============================

Name: p_mul_seq

Overview:
- Sequential packed multiplier for 32-bit words: the multi-cycle counterpart to the packed add/sub datapath.
- Multiplies each lane of lhs by the matching lane of rhs, unsigned. Lane width is selected by a one-hot pack width.
- Returns either the low or the high half of every 2W-bit lane product, repacked into 32 bits.
- Optional carry-less (GF(2)) mode for crypto instructions. Sits beside the packed ALU; the core stalls on the valid/ready handshake.

Parameters:
- none. Datapath is fixed at 32 bits.

Ports:
- g_clk  input  1  clock; all state updates on the rising edge.
- g_resetn  input  1  asynchronous active-low reset.
- valid  input  1  request valid. Held high by the requester until ready.
- flush  input  1  abort any operation in progress.
- lhs  input  32  multiplicand lanes.
- rhs  input  32  multiplier lanes.
- pw  input  5  one-hot pack width: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2.
- high  input  1  1: return high half of each lane product; 0: return low half.
- clmul  input  1  1: carry-less multiply (XOR accumulate); 0: integer multiply.
- ready  output  1  single-cycle pulse; result is valid in the same cycle.
- result  output  32  packed result.

Behaviour:
- Reset (async, g_resetn=0):
  - state=IDLE; ready=0; result=0; counter=0; operand and accumulator registers=0.
  - Takes effect immediately, including mid-operation. No partial result is ever emitted.
- Lane width W decode, priority order: pw[4]→2, pw[3]→4, pw[2]→8, pw[1]→16, else→32. pw=0 or multi-hot resolves by this order.
- States:
  - IDLE: valid=1 and flush=0 at an edge → capture lhs, rhs, W, high, clmul; clear the 64-bit accumulator; counter=0; go BUSY. Inputs after capture are ignored, except valid and flush.
  - BUSY: each cycle processes multiplier bit [counter] of every lane at once.
    - A lane whose bit is set adds (clmul=0) or XORs (clmul=1) its multiplicand, shifted left by counter, into that lane's 2W-bit product field.
    - Carries never cross a 2W-bit lane field boundary.
    - counter increments each cycle. After the cycle with counter==W-1, go DONE.
  - DONE: ready=1 for exactly one cycle.
    - result = lane i holds product_i[W-1:0] (high=0) or product_i[2W-1:W] (high=1), at bits [i*W+W-1 : i*W].
    - Next state is IDLE.
- Latency: valid sampled at edge t0 → ready high in the cycle after edge t0+W. That is W+1 cycles total: 33, 17, 9, 5 and 3 for widths 32 down to 2.
- result holds its last value when ready=0.
- Handshake:
  - The requester drops valid in the cycle after ready.
  - valid sampled high in IDLE starts a new operation, including on the cycle immediately after DONE.
- Abort: flush=1, or valid=0, at any edge while in BUSY → IDLE next cycle. ready is not asserted and result is unchanged.
- flush takes priority over acceptance in IDLE.
- Integer mode: exact unsigned product modulo 2^(2W) per lane. The full product fits, so nothing is lost.
- Carry-less mode: the product's top bit (bit 2W-1) is always 0.

Test Plan:
- pw=32, lhs=rhs=0xFFFFFFFF, clmul=0 → high=0: result 0x00000001; high=1: result 0xFFFFFFFE. ready exactly 33 cycles after accept, one-cycle pulse.
- pw=16, lhs=0xFFFF8000, rhs=0x00020002 → high=0: result 0xFFFE0000; high=1: result 0x00010001. Latency 17. Confirms no cross-lane carry.
- pw=8, clmul=1, lhs=rhs=0x03030303 → high=0: result 0x05050505; high=1: result 0x00000000. Latency 9.
- pw=2, lhs=rhs=0xFFFFFFFF, clmul=0 → high=0: result 0x55555555; high=1: result 0xAAAAAAAA. Latency 3. Check ready/valid back-to-back with a second request issued the cycle after ready.
- Abort: pw=32 op, flush=1 at the 5th BUSY cycle → ready never rises, state returns IDLE. A following op with lhs=7, rhs=6, pw=32 gives result 0x0000002A.
- Async reset: drop g_resetn mid-BUSY, between clock edges → ready=0 and result=0 immediately. After release, a fresh op completes correctly.

Source files
------------

// File: rtl/p_mul_seq.sv
// p_mul_seq: sequential packed multiplier that retires one multiplier bit per lane per cycle.
// Integer or carry-less lane products; the low or high half of each lane is repacked into 32 bits.
module p_mul_seq (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic        flush,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  pw,
    input  logic        high,
    input  logic        clmul,
    output logic        ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Lane width is W = 2 << wsel, so the encoding doubles as a generate index.
    typedef enum logic [2:0] {
        WS_2  = 3'd0,
        WS_4  = 3'd1,
        WS_8  = 3'd2,
        WS_16 = 3'd3,
        WS_32 = 3'd4
    } wsel_e;

    state_e      state_q, state_d;
    wsel_e       wsel_q, wsel_d, wsel_in;
    logic [4:0]  count_q, count_d;
    logic [31:0] lhs_q, lhs_d;
    logic [31:0] rhs_q, rhs_d;
    logic        high_q, high_d;
    logic        clmul_q, clmul_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;

    logic [63:0] addend;
    logic [63:0] top_mask;
    logic [63:0] acc_sum;
    logic [63:0] acc_next;
    logic [31:0] packed_res;
    logic [4:0]  last_cnt;

    // Lane width decode; pw=0 and multi-hot resolve by priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wsel_in = WS_32;
        if (pw[4])      wsel_in = WS_2;
        else if (pw[3]) wsel_in = WS_4;
        else if (pw[2]) wsel_in = WS_8;
        else if (pw[1]) wsel_in = WS_16;
    end

    // One lane layout per width: partial-product addend, field top-bit mask, result extraction.
    for (genvar g = 0; g < 5; g++) begin : g_width
        localparam int W = 2 << g;
        localparam int N = 32 / W;

        logic [g:0]  cnt_g;
        logic [63:0] addend_g;
        logic [63:0] mask_g;
        logic [31:0] res_g;

        assign cnt_g = count_q[g:0];

        for (genvar i = 0; i < N; i++) begin : g_lane
            logic [W-1:0] rhs_lane;
            assign rhs_lane = rhs_q[i*W +: W];
            assign addend_g[i*2*W +: 2*W] = rhs_lane[cnt_g]
                                          ? ({{W{1'b0}}, lhs_q[i*W +: W]} << cnt_g)
                                          : '0;
            assign mask_g[i*2*W +: 2*W]   = {1'b1, {(2*W-1){1'b0}}};
            assign res_g[i*W +: W]        = high_q ? acc_next[i*2*W + W +: W]
                                                   : acc_next[i*2*W +: W];
        end
    end

    always_comb begin
        addend     = g_width[4].addend_g;
        top_mask   = g_width[4].mask_g;
        packed_res = g_width[4].res_g;
        last_cnt   = 5'd31;
        case (wsel_q)
            WS_2: begin
                addend     = g_width[0].addend_g;
                top_mask   = g_width[0].mask_g;
                packed_res = g_width[0].res_g;
                last_cnt   = 5'd1;
            end
            WS_4: begin
                addend     = g_width[1].addend_g;
                top_mask   = g_width[1].mask_g;
                packed_res = g_width[1].res_g;
                last_cnt   = 5'd3;
            end
            WS_8: begin
                addend     = g_width[2].addend_g;
                top_mask   = g_width[2].mask_g;
                packed_res = g_width[2].res_g;
                last_cnt   = 5'd7;
            end
            WS_16: begin
                addend     = g_width[3].addend_g;
                top_mask   = g_width[3].mask_g;
                packed_res = g_width[3].res_g;
                last_cnt   = 5'd15;
            end
            default: ;
        endcase
    end

    // Segmented add: field top bits are summed by XOR so no carry leaves a 2W-bit field.
    assign acc_sum  = ((acc_q & ~top_mask) + (addend & ~top_mask)) ^ ((acc_q ^ addend) & top_mask);
    assign acc_next = clmul_q ? (acc_q ^ addend) : acc_sum;

    // State register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        // NOTE: datapath registers are reset too, so nothing stale is visible after reset.
        if (!g_resetn) begin
            state_q  <= IDLE;
            wsel_q   <= WS_32;
            count_q  <= '0;
            lhs_q    <= '0;
            rhs_q    <= '0;
            high_q   <= 1'b0;
            clmul_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            wsel_q   <= wsel_d;
            count_q  <= count_d;
            lhs_q    <= lhs_d;
            rhs_q    <= rhs_d;
            high_q   <= high_d;
            clmul_q  <= clmul_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        wsel_d   = wsel_q;
        count_d  = count_q;
        lhs_d    = lhs_q;
        rhs_d    = rhs_q;
        high_d   = high_q;
        clmul_d  = clmul_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid && !flush) begin
                    lhs_d   = lhs;
                    rhs_d   = rhs;
                    wsel_d  = wsel_in;
                    high_d  = high;
                    clmul_d = clmul;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush || !valid) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = acc_next;
                    count_d = count_q + 5'd1;
                    if (count_q == last_cnt) begin
                        result_d = packed_res;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        ready  = (state_q == DONE);
        result = result_q;
    end

endmodule

// File: tb/tb_p_mul_seq.sv
// Self-checking bench for p_mul_seq: directed cases plus randomized ops against a lane-arithmetic model.
module tb_p_mul_seq;

    logic        g_clk;
    logic        g_resetn;
    logic        valid;
    logic        flush;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  pw;
    logic        high;
    logic        clmul;
    logic        ready;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_exp = '0;

    p_mul_seq dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .valid    (valid),
        .flush    (flush),
        .lhs      (lhs),
        .rhs      (rhs),
        .pw       (pw),
        .high     (high),
        .clmul    (clmul),
        .ready    (ready),
        .result   (result)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected summary before timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input logic [4:0] p);
        if (p[4]) return 2;
        if (p[3]) return 4;
        if (p[2]) return 8;
        if (p[1]) return 16;
        return 32;
    endfunction

    // Reference: per-lane unsigned or GF(2) product, then pick the requested half.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] p, input bit hi, input bit cl);
        int              w;
        longint unsigned msk, x, y, prod, half, r;
        w   = width_of(p);
        msk = (64'd1 << w) - 64'd1;
        r   = 0;
        for (int i = 0; i < 32 / w; i++) begin
            x = (64'(a) >> (i * w)) & msk;
            y = (64'(b) >> (i * w)) & msk;
            if (cl) begin
                prod = 0;
                for (int k = 0; k < w; k++)
                    if (((y >> k) & 64'd1) != 0) prod = prod ^ (x << k);
            end else begin
                prod = x * y;
            end
            half = (hi ? (prod >> w) : prod) & msk;
            r    = r | (half << (i * w));
        end
        return r[31:0];
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] p, input bit hi, input bit cl, input logic [31:0] exp);
        int lat;
        bit seen;
        @(negedge g_clk);
        check({tag, "_idle_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_held_result"}, result, last_exp);
        lhs = a; rhs = b; pw = p; high = hi; clmul = cl; valid = 1'b1; flush = 1'b0;
        @(posedge g_clk);
        #1;
        lhs = $urandom; rhs = $urandom; pw = 5'($urandom); high = 1'($urandom); clmul = 1'($urandom);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge g_clk);
            if (ready) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, "_ready_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, lat, width_of(p) + 1);
        check({tag, "_result"}, result, exp);
        valid    = 1'b0;
        last_exp = exp;
    endtask

    task automatic no_ready_for(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge g_clk);
            if (ready) seen = 1'b1;
        end
        check({tag, "_no_ready"}, {31'd0, seen}, 32'd0);
        check({tag, "_result_kept"}, result, last_exp);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [4:0]  p;
        bit          hi, cl;
        int          lat;

        g_resetn = 1'b0;
        valid = 1'b0; flush = 1'b0; lhs = '0; rhs = '0; pw = 5'd1; high = 1'b0; clmul = 1'b0;
        repeat (2) @(negedge g_clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_result", result, 32'd0);
        g_resetn = 1'b1;

        run_op("w32_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, 1'b0, 1'b0, 32'h0000_0001);
        run_op("w32_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, 1'b1, 1'b0, 32'hFFFF_FFFE);
        run_op("w16_lo", 32'hFFFF_8000, 32'h0002_0002, 5'b00010, 1'b0, 1'b0, 32'hFFFE_0000);
        run_op("w16_hi", 32'hFFFF_8000, 32'h0002_0002, 5'b00010, 1'b1, 1'b0, 32'h0001_0001);
        run_op("w8_cl_lo", 32'h0303_0303, 32'h0303_0303, 5'b00100, 1'b0, 1'b1, 32'h0505_0505);
        run_op("w8_cl_hi", 32'h0303_0303, 32'h0303_0303, 5'b00100, 1'b1, 1'b1, 32'h0000_0000);
        run_op("w2_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 1'b0, 1'b0, 32'h5555_5555);
        run_op("w2_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 1'b1, 1'b0, 32'hAAAA_AAAA);
        run_op("w4_b2b", 32'h1234_5678, 32'h9ABC_DEF0, 5'b01000, 1'b0, 1'b0,
               model(32'h1234_5678, 32'h9ABC_DEF0, 5'b01000, 1'b0, 1'b0));

        // Flush on the 5th busy cycle of a 32-bit op.
        @(negedge g_clk);
        lhs = 32'hDEAD_BEEF; rhs = 32'h1357_9BDF; pw = 5'b00001; high = 1'b0; clmul = 1'b0; valid = 1'b1;
        @(posedge g_clk);
        for (int c = 1; c <= 5; c++) @(negedge g_clk);
        flush = 1'b1;
        @(posedge g_clk);
        #1 flush = 1'b0; valid = 1'b0;
        no_ready_for("flush_abort", 40);
        run_op("after_flush", 32'd7, 32'd6, 5'b00001, 1'b0, 1'b0, 32'h0000_002A);

        // Requester withdraws valid mid-operation.
        @(negedge g_clk);
        lhs = 32'h0F0F_0F0F; rhs = 32'hFFFF_FFFF; pw = 5'b00100; valid = 1'b1;
        @(posedge g_clk);
        repeat (3) @(negedge g_clk);
        valid = 1'b0;
        no_ready_for("valid_abort", 20);

        // flush beats acceptance in IDLE: the op starts one edge later.
        @(negedge g_clk);
        lhs = 32'hFFFF_FFFF; rhs = 32'hFFFF_FFFF; pw = 5'b10000; high = 1'b0; clmul = 1'b0;
        valid = 1'b1; flush = 1'b1;
        @(posedge g_clk);
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge g_clk);
            flush = 1'b0;
            if (ready) lat = c;
        end
        check("flush_prio_latency", lat, 4);
        check("flush_prio_result", result, 32'h5555_5555);
        valid    = 1'b0;
        last_exp = 32'h5555_5555;

        // Asynchronous reset between clock edges in the middle of an op.
        @(negedge g_clk);
        lhs = 32'h89AB_CDEF; rhs = 32'h7654_3210; pw = 5'b00001; valid = 1'b1;
        @(posedge g_clk);
        repeat (3) @(negedge g_clk);
        #2 g_resetn = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, ready}, 32'd0);
        check("async_rst_result", result, 32'd0);
        valid = 1'b0;
        @(negedge g_clk);
        check("rst_held_ready", {31'd0, ready}, 32'd0);
        g_resetn = 1'b1;
        last_exp = '0;
        run_op("post_reset", 32'h0001_0003, 32'h0002_0005, 5'b00010, 1'b0, 1'b0, 32'h0002_000F);

        // Randomized ops over every pw pattern, both halves and both modes.
        for (int n = 0; n < 80; n++) begin
            a  = $urandom;
            b  = $urandom;
            p  = 5'($urandom_range(0, 31));
            hi = 1'($urandom_range(0, 1));
            cl = 1'($urandom_range(0, 1));
            run_op("rand", a, b, p, hi, cl, model(a, b, p, hi, cl));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
